tx_serial_fifo_cfg: RTL and testbench

Parametrised asynchronous serial transmitter with configurable word length, parity mode, stop-bit count and baud divisor, fronted by a small write FIFO so a producer can queue several characters without waiting for each frame. It is the next-generation transmitter for the board's serial debug/telemetry path. It replaces the fixed 8N1 transmitter and its external start-pulse edge detection with a level-tolerant write/full handshake. Frames are sent back to back while the FIFO is non-empty.

---
 rtl/tx_serial_fifo_cfg.sv | 221 ++++++++++++++++++++++
 tb/tb_tx_serial_fifo_cfg.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_serial_fifo_cfg.sv
// Asynchronous serial transmitter with configurable word length, parity and stop bits.
// A small write FIFO in front of it lets queued characters go out back to back.
module tx_serial_fifo_cfg #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] dados,
  input  logic                 escreve,
  output logic                 cheio,
  output logic                 vazio,
  output logic                 saida_serial,
  output logic                 ocupado,
  output logic                 pronto,
  output logic                 erro_overflow,
  output logic [3:0]           db_estado
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
    S_PARITY = 4'd3,
    S_STOP   = 4'd4
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;
  logic                 pronto_q, pronto_d;
  logic                 ocupado_q, ocupado_d;
  logic                 ovf_q, ovf_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 cheio_q, cheio_d;
  logic                 vazio_q, vazio_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic                 push_s, pop_s, tick_s;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~^d;
    end else begin
      return ^d;
    end
  endfunction

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q[wptr_q] <= dados;
    end
  end

  // FIFO bookkeeping: a write into a full FIFO is dropped even if a pop frees a slot on that edge.
  always_comb begin
    push_s  = escreve & ~cheio_q;
    ovf_d   = ovf_q | (escreve & cheio_q);
    wptr_d  = push_s ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop_s ? rptr_q + PW'(1) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    cheio_d = (count_d == COUNT_FULL);
    vazio_d = (count_d == '0);
  end

  // Frame sequencer; the line level is derived from the next state so it can be registered.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    par_d    = par_q;
    pronto_d = 1'b0;
    pop_s    = 1'b0;
    tick_s   = (timer_q == TIMER_LAST);
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!vazio_q) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rptr_q];
          par_d   = calc_parity(mem_q[rptr_q]);
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        timer_d = tick_s ? '0 : timer_q + TW'(1);
        if (tick_s) begin
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        timer_d = tick_s ? '0 : timer_q + TW'(1);
        if (tick_s) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            stop_d  = 1'b0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        timer_d = tick_s ? '0 : timer_q + TW'(1);
        if (tick_s) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        timer_d = tick_s ? '0 : timer_q + TW'(1);
        if (tick_s && (stop_q == STOP_LAST)) begin
          pronto_d = 1'b1;
          if (!vazio_q) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rptr_q];
            par_d   = calc_parity(mem_q[rptr_q]);
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else if (tick_s) begin
          stop_d = 1'b1;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
    ocupado_d = (state_d != S_IDLE);
  end

  // State and output registers; reset drives the line high at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      line_q    <= 1'b1;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      cheio_q   <= 1'b0;
      vazio_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      line_q    <= line_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      cheio_q   <= cheio_d;
      vazio_q   <= vazio_d;
    end
  end

  assign cheio         = cheio_q;
  assign vazio         = vazio_q;
  assign saida_serial  = line_q;
  assign ocupado       = ocupado_q;
  assign pronto        = pronto_q;
  assign erro_overflow = ovf_q;
  assign db_estado     = state_q;

endmodule

// File: tb/tb_tx_serial_fifo_cfg.sv
// Scoreboard bench: stimulus queues expected line frames, per-instance monitors decode and compare.
// Instance 0 is 8N1, instance 1 is 7E2, instance 2 is 7O2; all use CLK_DIV=4 and a 4-deep FIFO.
module tb_tx_serial_fifo_cfg;

  typedef struct {
    int          id;
    logic [15:0] bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] esc;
  logic [8:0] din [3];
  logic [2:0] line_w, pronto_w, cheio_w, vazio_w, ocup_w, ovf_w;
  logic [3:0] est_w [3];

  exp_t sb[$];
  int   pron_times[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   rst_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rst) rst_cnt <= rst_cnt + 1;
  always @(negedge clk) if (pronto_w[0] === 1'b1) pron_times.push_back(cyc);

  tx_serial_fifo_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clock(clk), .reset(rst), .dados(din[0][7:0]), .escreve(esc[0]),
    .cheio(cheio_w[0]), .vazio(vazio_w[0]), .saida_serial(line_w[0]), .ocupado(ocup_w[0]),
    .pronto(pronto_w[0]), .erro_overflow(ovf_w[0]), .db_estado(est_w[0]));

  tx_serial_fifo_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clock(clk), .reset(rst), .dados(din[1][6:0]), .escreve(esc[1]),
    .cheio(cheio_w[1]), .vazio(vazio_w[1]), .saida_serial(line_w[1]), .ocupado(ocup_w[1]),
    .pronto(pronto_w[1]), .erro_overflow(ovf_w[1]), .db_estado(est_w[1]));

  tx_serial_fifo_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clock(clk), .reset(rst), .dados(din[2][6:0]), .escreve(esc[2]),
    .cheio(cheio_w[2]), .vazio(vazio_w[2]), .saida_serial(line_w[2]), .ocupado(ocup_w[2]),
    .pronto(pronto_w[2]), .erro_overflow(ovf_w[2]), .db_estado(est_w[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input int g, input logic [15:0] bits);
    exp_t e;
    e.id   = g;
    e.bits = bits;
    sb.push_back(e);
  endtask

  task automatic drive(input int g, input logic [8:0] d, input int n);
    esc[g] = 1'b1;
    din[g] = d;
    repeat (n) @(negedge clk);
    esc[g] = 1'b0;
  endtask

  task automatic wait_pronto(input int g, output int k);
    k = 0;
    while (pronto_w[g] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(input int g);
    int k;
    k = 0;
    while (!(vazio_w[g] === 1'b1 && ocup_w[g] === 1'b0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_within_budget", 32'(k < 1000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Line monitors: sample mid-bit after each start edge, LSB-first into a frame word.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int NBITS = (g == 0) ? 10 : 11;
    initial begin
      logic [15:0] got;
      int          rc;
      exp_t        e;
      forever begin
        @(negedge line_w[g]);
        rc  = rst_cnt;
        got = '0;
        for (int b = 0; b < NBITS; b++) begin
          repeat ((b == 0) ? 2 : 4) @(negedge clk);
          got[b] = line_w[g];
        end
        if (rc == rst_cnt && rst == 1'b0) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL frame_%0d: got unexpected frame %h, required none", g, got);
          end else begin
            e = sb.pop_front();
            if (e.id != g || e.bits !== got) begin
              fails++;
              $display("FAIL frame_%0d: got %h on dut %0d, required %h on dut %0d", g, got, g, e.bits, e.id);
            end
          end
        end
      end
    end
  end

  initial begin
    int k;
    esc = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 9'h000;
    #2 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk("reset_state", {22'd0, line_w[i], cheio_w[i], vazio_w[i], ocup_w[i], pronto_w[i], ovf_w[i], est_w[i]},
          32'h280);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pron_times.delete();

    // 8N1, 0x55
    expect_frame(0, 16'h02AA);
    drive(0, 9'h055, 1);
    chk("t1_vazio_after_write", 32'(vazio_w[0]), 32'd0);
    @(negedge clk);
    chk("t1_start_bit", 32'(line_w[0]), 32'd0);
    chk("t1_ocupado", 32'(ocup_w[0]), 32'd1);
    chk("t1_vazio_after_pop", 32'(vazio_w[0]), 32'd1);
    chk("t1_state_start", 32'(est_w[0]), 32'd1);
    wait_pronto(0, k);
    chk("t1_frame_len", 32'(k), 32'd40);
    chk("t1_ocupado_end", 32'(ocup_w[0]), 32'd0);
    chk("t1_vazio_end", 32'(vazio_w[0]), 32'd1);
    @(negedge clk);
    chk("t1_pronto_one_cycle", 32'(pronto_w[0]), 32'd0);
    chk("t1_pronto_count", 32'(pron_times.size()), 32'd1);
    wait_idle(0);

    // 7E2, 0x41: even parity bit 0
    expect_frame(1, 16'h0682);
    drive(1, 9'h041, 1);
    @(negedge clk);
    repeat (33) @(negedge clk);
    chk("t2_state_parity", 32'(est_w[1]), 32'd3);
    chk("t2_parity_bit", 32'(line_w[1]), 32'd0);
    wait_pronto(1, k);
    chk("t2_frame_len", 32'(33 + k), 32'd44);
    wait_idle(1);

    // 7O2, 0x41: odd parity bit 1
    expect_frame(2, 16'h0782);
    drive(2, 9'h041, 1);
    @(negedge clk);
    repeat (33) @(negedge clk);
    chk("t3_parity_bit", 32'(line_w[2]), 32'd1);
    wait_pronto(2, k);
    chk("t3_frame_len", 32'(33 + k), 32'd44);
    wait_idle(2);

    // Overflow: six held writes, five accepted, 0x06 dropped
    pron_times.delete();
    expect_frame(0, 16'h0202);
    expect_frame(0, 16'h0204);
    expect_frame(0, 16'h0206);
    expect_frame(0, 16'h0208);
    expect_frame(0, 16'h020A);
    for (int i = 1; i <= 6; i++) drive(0, 9'(i), 1);
    chk("t4_cheio", 32'(cheio_w[0]), 32'd1);
    chk("t4_overflow", 32'(ovf_w[0]), 32'd1);
    wait_idle(0);
    chk("t4_pronto_count", 32'(pron_times.size()), 32'd5);
    for (int i = 1; i < 5 && i < pron_times.size(); i++)
      chk("t4_pronto_spacing", 32'(pron_times[i] - pron_times[i-1]), 32'd40);

    // Write and pop on the same edge with two entries queued
    expect_frame(0, 16'h0222);
    expect_frame(0, 16'h0244);
    expect_frame(0, 16'h0266);
    expect_frame(0, 16'h0288);
    drive(0, 9'h011, 1);
    drive(0, 9'h022, 1);
    drive(0, 9'h033, 1);
    repeat (38) @(negedge clk);
    drive(0, 9'h044, 1);
    chk("t5_pronto_aligned", 32'(pronto_w[0]), 32'd1);
    chk("t5_count_kept", 32'(dut_a.count_q), 32'd2);
    chk("t5_vazio", 32'(vazio_w[0]), 32'd0);
    chk("t5_cheio", 32'(cheio_w[0]), 32'd0);
    wait_idle(0);

    // Reset during DATA of frame 1 with three entries queued
    chk("t6_overflow_before", 32'(ovf_w[0]), 32'd1);
    drive(0, 9'h0A1, 1);
    drive(0, 9'h0A2, 1);
    drive(0, 9'h0A3, 1);
    drive(0, 9'h0A4, 1);
    repeat (7) @(negedge clk);
    chk("t6_state_data", 32'(est_w[0]), 32'd2);
    chk("t6_line_low", 32'(line_w[0]), 32'd0);
    #2 rst = 1'b1;
    #1 chk("t6_line_async_high", 32'(line_w[0]), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_vazio", 32'(vazio_w[0]), 32'd1);
    chk("t6_state_idle", 32'(est_w[0]), 32'd0);
    chk("t6_overflow_clear", 32'(ovf_w[0]), 32'd0);
    chk("t6_ocupado", 32'(ocup_w[0]), 32'd0);
    repeat (100) @(negedge clk);
    chk("t6_line_idle", 32'(line_w[0]), 32'd1);
    chk("t6_no_frames_left", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
